// File: rtl/online_otf_converter.sv
// Signed-digit type shared with the online divider, plus an on-the-fly converter
// that turns an MSDF quotient digit stream into a two's-complement result.
package rbr_pkg;
    typedef struct packed {
        logic plus;
        logic minus;
    } signed_digit;
endpackage

module online_otf_converter
    import rbr_pkg::*;
#(
    parameter int WIDTH        = 48,
    parameter int ONLINE_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        en,
    input  signed_digit q,
    output logic [WIDTH:0] result,
    output logic        valid,
    output logic        busy
);

    localparam int CW = $clog2(ONLINE_DELAY + WIDTH + 1);
    localparam logic [CW-1:0] SKIP_END    = CW'(ONLINE_DELAY);
    localparam logic [CW-1:0] COLLECT_END = CW'(ONLINE_DELAY + WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        COLLECT,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [WIDTH:0]  acc_q;
    logic [WIDTH:0]  acc_qm;
    logic [WIDTH:0]  q_nxt;
    logic [WIDTH:0]  qm_nxt;
    logic            digit_pos;
    logic            digit_neg;

    // {1,1} falls through to the zero-digit branch along with {0,0}.
    assign digit_pos = q.plus & ~q.minus;
    assign digit_neg = q.minus & ~q.plus;
    assign cnt_inc   = cnt + CW'(1);

    // Q tracks the converted value, QM tracks Q-1 in the same weight.
    always_comb begin
        q_nxt  = {acc_q[WIDTH-1:0], 1'b0};
        qm_nxt = {acc_qm[WIDTH-1:0], 1'b1};
        if (digit_pos) begin
            q_nxt  = {acc_q[WIDTH-1:0], 1'b1};
            qm_nxt = {acc_q[WIDTH-1:0], 1'b0};
        end else if (digit_neg) begin
            q_nxt  = {acc_qm[WIDTH-1:0], 1'b1};
            qm_nxt = {acc_qm[WIDTH-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_q  <= '0;
            acc_qm <= '1;
            result <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                // A start in any state aborts whatever is in flight.
                cnt    <= '0;
                acc_q  <= '0;
                acc_qm <= '1;
                busy   <= 1'b1;
                state  <= (ONLINE_DELAY == 0) ? COLLECT : SKIP;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SKIP: begin
                        if (en) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == SKIP_END) begin
                                state <= COLLECT;
                            end
                        end
                    end
                    COLLECT: begin
                        if (en) begin
                            cnt    <= cnt_inc;
                            acc_q  <= q_nxt;
                            acc_qm <= qm_nxt;
                            if (cnt_inc == COLLECT_END) begin
                                state  <= DONE;
                                result <= q_nxt;
                                valid  <= 1'b1;
                                busy   <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed bench for the on-the-fly converter at WIDTH=4, ONLINE_DELAY=2.
module tb_online_otf_converter;
    import rbr_pkg::*;

    localparam int W = 4;
    localparam int D = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        en;
    signed_digit q;
    logic [W:0]  result;
    logic        valid;
    logic        busy;

    int n_cmp;
    int n_err;

    online_otf_converter #(
        .WIDTH       (W),
        .ONLINE_DELAY(D)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .q     (q),
        .result(result),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic s, input logic e, input logic [1:0] d);
        start = s;
        en    = e;
        q     = d;
        @(posedge clk);
        #1;
    endtask

    // Start cycle, then n cycles following en_pat (bit i = en in cycle i), digits
    // consumed in order on en cycles; then 3 quiet cycles to catch stray pulses.
    task automatic run_seq(input int n, input logic [15:0] en_pat, input logic [11:0] digs,
                           output int vidx, output int vcount, output logic [W:0] res,
                           output logic [W:0] res_after);
        int k;
        k      = 0;
        vidx   = -1;
        vcount = 0;
        res    = '0;
        cycle(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < n; i++) begin
            if (en_pat[i]) begin
                cycle(1'b0, 1'b1, digs[2*(5-k) +: 2]);
                k++;
            end else begin
                cycle(1'b0, 1'b0, 2'b11);
            end
            if (valid) begin
                if (vidx < 0) begin
                    vidx = i;
                    res  = result;
                end
                vcount++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 2'b10);
            if (valid) vcount++;
        end
        res_after = result;
    endtask

    int         vidx;
    int         vcount;
    logic [W:0] res;
    logic [W:0] res_after;
    int         early_valid;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b1;
        en    = 1'b1;
        q     = 2'b10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 2'b00);

        // +1,0,-1,+1 after two ignored digits -> 7
        run_seq(6, 16'h003F, 12'b10_01_10_00_01_10, vidx, vcount, res, res_after);
        check("basic_vidx", 32'(vidx), 32'd5);
        check("basic_result", 32'(res), 32'h07);
        check("basic_vcount", 32'(vcount), 32'd1);
        check("basic_hold", 32'(res_after), 32'h07);
        check("basic_busy_idle", 32'(busy), 32'h0);

        run_seq(6, 16'h003F, 12'b00_00_01_01_01_01, vidx, vcount, res, res_after);
        check("neg15_vidx", 32'(vidx), 32'd5);
        check("neg15_result", 32'(res), 32'h11);
        check("neg15_vcount", 32'(vcount), 32'd1);

        run_seq(6, 16'h003F, 12'b01_01_10_01_01_01, vidx, vcount, res, res_after);
        check("one_result", 32'(res), 32'h01);
        check("one_vcount", 32'(vcount), 32'd1);

        // {1,1} digits decode as zero
        run_seq(6, 16'h003F, 12'b00_00_11_11_11_11, vidx, vcount, res, res_after);
        check("zero11_result", 32'(res), 32'h00);
        check("zero11_vcount", 32'(vcount), 32'd1);

        // 3 stalls in SKIP, 2 stalls in COLLECT -> valid 5 cycles later
        run_seq(11, 16'h0731, 12'b10_01_10_00_01_10, vidx, vcount, res, res_after);
        check("stall_vidx", 32'(vidx), 32'd10);
        check("stall_result", 32'(res), 32'h07);
        check("stall_vcount", 32'(vcount), 32'd1);

        // Abort after 3 COLLECT digits, then restart with the all -1 stream
        early_valid = 0;
        cycle(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 2'b10);
            if (valid) early_valid++;
        end
        check("abort_busy", 32'(busy), 32'h1);
        run_seq(6, 16'h003F, 12'b00_00_01_01_01_01, vidx, vcount, res, res_after);
        check("abort_novalid", 32'(early_valid), 32'd0);
        check("abort_vidx", 32'(vidx), 32'd5);
        check("abort_result", 32'(res), 32'h11);
        check("abort_vcount", 32'(vcount), 32'd1);

        // Reset mid-COLLECT discards everything; en alone never produces valid
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b1, 2'b10);
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        cycle(1'b0, 1'b1, 2'b10);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_result", 32'(result), 32'h0);
        early_valid = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 2'b10);
            if (valid || busy) early_valid++;
        end
        check("postrst_quiet", 32'(early_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
